// File: rtl/timer_top_canuz_o_if.sv
// Control/status bundle for the reminder interval timer: run enable and
// interval select in, sticky expiry flag out.
interface timer_top_canuz_o_if;
  logic cfg;
  logic ena;
  logic tm_out;

  modport master (output cfg, output ena, input tm_out);
  modport slave  (input cfg, input ena, output tm_out);
endinterface

// File: rtl/timer_top_canuz_o.sv
// Medicine-reminder interval timer: tm_out rises N*TICK_DIV cycles after the enable edge
// (N picked by cfg latched at start) and stays high until ena drops; no backpressure.
module timer_top_canuz_o #(
  parameter int TICK_DIV = 50000,
  parameter int T0_MS    = 1000,
  parameter int T1_MS    = 2000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  timer_top_canuz_o_if.slave tmr
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (T0_MS > T1_MS) ? T0_MS : T1_MS;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] TERM0    = CW'(T0_MS - 1);
  localparam logic [CW-1:0] TERM1    = CW'(T1_MS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [CW-1:0] ms_cnt_q, ms_cnt_d;
  logic          cfg_q, cfg_d;
  logic          tm_out_q, tm_out_d;
  logic          tick;
  logic [CW-1:0] term;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      ms_cnt_q    <= '0;
      cfg_q       <= 1'b0;
      tm_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      ms_cnt_q    <= ms_cnt_d;
      cfg_q       <= cfg_d;
      tm_out_q    <= tm_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    ms_cnt_d    = ms_cnt_q;
    cfg_d       = cfg_q;
    tick        = (state_q == RUN) && (prescaler_q == PRE_LAST);
    term        = cfg_q ? TERM1 : TERM0;

    case (state_q)
      IDLE: begin
        prescaler_d = '0;
        ms_cnt_d    = '0;
        if (tmr.ena) begin
          // The enabling edge is cycle 1 of the interval; prescaler stays 0.
          state_d = RUN;
          cfg_d   = tmr.cfg;
        end
      end
      RUN: begin
        if (!tmr.ena) begin
          // Abort takes priority over a coincident terminal tick.
          state_d     = IDLE;
          prescaler_d = '0;
          ms_cnt_d    = '0;
        end else if (tick) begin
          prescaler_d = '0;
          if (ms_cnt_q == term) begin
            state_d = DONE;
          end else begin
            ms_cnt_d = ms_cnt_q + CW'(1);
          end
        end else begin
          prescaler_d = prescaler_q + PW'(1);
        end
      end
      DONE: begin
        if (!tmr.ena) begin
          state_d     = IDLE;
          prescaler_d = '0;
          ms_cnt_d    = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        prescaler_d = '0;
        ms_cnt_d    = '0;
      end
    endcase

    tm_out_d = (state_d == DONE);
  end

  assign tmr.tm_out = tm_out_q;

endmodule

// File: tb/tb_timer_top_canuz_o.sv
// Bench for timer_top_canuz_o with a scaled-down tick (4 cycles) and intervals of 3/5 ticks.
module tb_timer_top_canuz_o;

  localparam int TICK_DIV = 4;
  localparam int T0_MS    = 3;
  localparam int T1_MS    = 5;

  logic clk;
  logic rst_n;

  timer_top_canuz_o_if tif ();

  timer_top_canuz_o #(
    .TICK_DIV(TICK_DIV),
    .T0_MS   (T0_MS),
    .T1_MS   (T1_MS)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tmr   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  exp;
    string nm;
  } exp_t;

  typedef struct {
    logic  rst_n;
    logic  ena;
    logic  cfg;
    int    n;
    logic  exp;
    string nm;
  } vec_t;

  exp_t sb[$];
  exp_t it;
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; expectation refers to tm_out after the next rising edge.
  task automatic drive(input logic r, input logic e, input logic c, input logic x,
                       input string nm);
    @(negedge clk);
    rst_n   = r;
    tif.ena = e;
    tif.cfg = c;
    sb.push_back('{x, nm});
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      it = sb.pop_front();
      check(it.nm, int'(tif.tm_out), int'(it.exp));
    end
  end

  initial begin
    rst_n   = 1'b0;
    tif.ena = 1'b1;
    tif.cfg = 1'b0;
    #2;
    check("reset_tm_out", int'(tif.tm_out), 0);
    check("reset_state", int'(dut.state_q), 0);

    // Interval of 3 ticks x 4 cycles: low through edge 12, high from edge 13.
    tbl.push_back('{1'b0, 1'b1, 1'b0, 3,  1'b0, "s1_in_reset"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 1'b0, "s1_counting"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b1, "s1_expired"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  1'b0, "s1_idle"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 1'b0, "s2_counting"});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 4,  1'b1, "s2_sticky"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, "s2_drop"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, "s2_idle"});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 5,  1'b0, "s3_cfg1"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 15, 1'b0, "s3_cfg_toggled"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 2,  1'b1, "s3_expired"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, "s3_drop"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 8,  1'b0, "s4_first_run"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  1'b0, "s4_abort"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 1'b0, "s4_restart"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b1, "s4_expired"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, "s4_drop"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 1'b0, "term_abort_run"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  1'b0, "term_abort_wins"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 12, 1'b0, "term_rerun"});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1,  1'b1, "term_rerun_done"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  1'b0, "term_drop"});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].rst_n, tbl[i].ena, tbl[i].cfg, tbl[i].exp, tbl[i].nm);
      end
    end
    repeat (2) @(negedge clk);

    // Async reset between edges in the middle of a run.
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, "s5_pre");
    @(posedge clk);
    #3;
    check("s5_prescaler_before", int'(dut.prescaler_q), 2);
    check("s5_ms_cnt_before", int'(dut.ms_cnt_q), 1);
    rst_n = 1'b0;
    #1;
    check("s5_tm_out_async", int'(tif.tm_out), 0);
    check("s5_prescaler_async", int'(dut.prescaler_q), 0);
    check("s5_ms_cnt_async", int'(dut.ms_cnt_q), 0);
    check("s5_state_async", int'(dut.state_q), 0);
    for (int k = 0; k < 2; k++)  drive(1'b0, 1'b1, 1'b0, 1'b0, "s5_hold");
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, "s5_fresh_run");
    drive(1'b1, 1'b1, 1'b0, 1'b1, "s5_fresh_done");

    // Async reset while DONE drops the flag without waiting for an edge.
    @(posedge clk);
    #3;
    check("done_before_rst", int'(tif.tm_out), 1);
    rst_n = 1'b0;
    #1;
    check("done_rst_async", int'(tif.tm_out), 0);
    check("done_rst_cfg_q", int'(dut.cfg_q), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, "done_rst_released");
    drive(1'b1, 1'b0, 1'b0, 1'b0, "done_rst_idle");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
